// File: rtl/data_path.sv
// data_path: single-cycle MIPS-style datapath with a fixed program ROM.
//   clock          : rising-edge clock for all state
//   resetN         : synchronous active-low reset (PC and r1..r31 cleared)
//   pcQ            : current program counter
//   instruction    : ROM word at pcQ[31:2] (0 beyond IMEM_WORDS)
//   pcD            : next program counter (combinational)
//   regWriteEnable : register-file write strobe decoded from instruction
// PATCH_* parameters replace one ROM word, used to build program variants.

module data_path_regfile (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        we_i,
  input  logic [4:0]  rs_addr_i,
  input  logic [4:0]  rt_addr_i,
  input  logic [4:0]  wa_i,
  input  logic [31:0] wd_i,
  output logic [31:0] rs_data_o,
  output logic [31:0] rt_data_o
);
  logic [31:0] regs_q [32];
  logic        yesWrite0;

  // Writes aimed at r0 are discarded so r0 stays zero.
  assign yesWrite0 = we_i & (wa_i == 5'd0);

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      for (int unsigned i = 0; i < 32; i++) regs_q[i] <= '0;
    end else if (we_i && !yesWrite0) begin
      regs_q[wa_i] <= wd_i;
    end
  end

  // Combinational reads see the pre-edge contents on a same-cycle write.
  assign rs_data_o = (rs_addr_i == 5'd0) ? '0 : regs_q[rs_addr_i];
  assign rt_data_o = (rt_addr_i == 5'd0) ? '0 : regs_q[rt_addr_i];
endmodule

module data_path #(
  parameter int unsigned IMEM_WORDS  = 64,
  parameter bit          PATCH_EN    = 1'b0,
  parameter logic [29:0] PATCH_INDEX = '0,
  parameter logic [31:0] PATCH_WORD  = '0
) (
  input  logic        clock,
  input  logic        resetN,
  output logic [31:0] pcQ,
  output logic [31:0] instruction,
  output logic [31:0] pcD,
  output logic        regWriteEnable
);
  localparam logic [29:0] DEPTH = 30'(IMEM_WORDS);

  logic [29:0] wordIdx;
  logic [31:0] romWord;
  logic [31:0] pcPlus4;
  logic [5:0]  op;
  logic [5:0]  funct;
  logic [4:0]  rs;
  logic [4:0]  rt;
  logic [4:0]  rd;
  logic [4:0]  dest;
  logic [31:0] immExt;
  logic [31:0] rsData;
  logic [31:0] rtData;
  logic [31:0] aluResult;

  // Instruction ROM
  assign wordIdx = pcQ[31:2];

  always_comb begin
    romWord = '0;
    case (wordIdx)
      30'd0:   romWord = 32'h2001_0005;
      30'd1:   romWord = 32'h2002_000A;
      30'd2:   romWord = 32'h0022_1820;
      30'd3:   romWord = 32'h0000_0000;
      30'd4:   romWord = 32'h1000_0001;
      30'd5:   romWord = 32'h2004_0001;
      30'd6:   romWord = 32'h0800_0000;
      default: romWord = '0;
    endcase
    if (PATCH_EN && (wordIdx == PATCH_INDEX)) romWord = PATCH_WORD;
    if (wordIdx >= DEPTH) romWord = '0;
  end

  assign instruction = romWord;

  // Field extraction
  assign op     = instruction[31:26];
  assign rs     = instruction[25:21];
  assign rt     = instruction[20:16];
  assign rd     = instruction[15:11];
  assign funct  = instruction[5:0];
  assign immExt = {{16{instruction[15]}}, instruction[15:0]};

  data_path_regfile theRegisters (
    .clk_i     (clock),
    .rst_n_i   (resetN),
    .we_i      (regWriteEnable),
    .rs_addr_i (rs),
    .rt_addr_i (rt),
    .wa_i      (dest),
    .wd_i      (aluResult),
    .rs_data_o (rsData),
    .rt_data_o (rtData)
  );

  // Decode + ALU; anything unrecognised falls through as a nop.
  always_comb begin
    regWriteEnable = 1'b0;
    dest           = rd;
    aluResult      = '0;
    case (op)
      6'h00: begin
        dest = rd;
        case (funct)
          6'h20: begin aluResult = rsData + rtData; regWriteEnable = 1'b1; end
          6'h22: begin aluResult = rsData - rtData; regWriteEnable = 1'b1; end
          6'h24: begin aluResult = rsData & rtData; regWriteEnable = 1'b1; end
          6'h25: begin aluResult = rsData | rtData; regWriteEnable = 1'b1; end
          6'h2A: begin
            aluResult      = {31'b0, $signed(rsData) < $signed(rtData)};
            regWriteEnable = 1'b1;
          end
          default: ;
        endcase
      end
      6'h08: begin
        dest           = rt;
        aluResult      = rsData + immExt;
        regWriteEnable = 1'b1;
      end
      default: ;
    endcase
  end

  // Next PC
  assign pcPlus4 = pcQ + 32'd4;

  always_comb begin
    pcD = pcPlus4;
    if (op == 6'h02) begin
      pcD = {pcPlus4[31:28], instruction[25:0], 2'b00};
    end else if ((op == 6'h04) && (rsData == rtData)) begin
      pcD = pcPlus4 + {immExt[29:0], 2'b00};
    end
  end

  always_ff @(posedge clock) begin
    if (!resetN) pcQ <= '0;
    else         pcQ <= pcD;
  end
endmodule

// File: tb/tb_data_path.sv
module tb_data_path;
  logic        clock;
  logic        resetN;
  logic [31:0] pcQ, instruction, pcD;
  logic        regWriteEnable;
  logic [31:0] pcQ2, instruction2, pcD2;
  logic        regWriteEnable2;

  int compared   = 0;
  int mismatched = 0;
  bit chk_en     = 0;

  data_path #(.IMEM_WORDS(64)) dut (
    .clock(clock), .resetN(resetN), .pcQ(pcQ), .instruction(instruction),
    .pcD(pcD), .regWriteEnable(regWriteEnable)
  );

  // Variant: short ROM (words >= 5 read as 0) with the nop at 0x0C
  // replaced by add r0,r1,r2.
  data_path #(
    .IMEM_WORDS(5), .PATCH_EN(1'b1), .PATCH_INDEX(30'd3), .PATCH_WORD(32'h0022_0020)
  ) dut2 (
    .clock(clock), .resetN(resetN), .pcQ(pcQ2), .instruction(instruction2),
    .pcD(pcD2), .regWriteEnable(regWriteEnable2)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // ---------------- ISA-level reference model ----------------
  logic [31:0] m_pc [2];
  logic [31:0] m_rf [2][32];

  function automatic logic [31:0] rom_word(input int k, input logic [31:0] pc);
    logic [31:0] idx;
    logic [31:0] w;
    idx = {2'b00, pc[31:2]};
    case (idx)
      0: w = 32'h2001_0005;
      1: w = 32'h2002_000A;
      2: w = 32'h0022_1820;
      4: w = 32'h1000_0001;
      5: w = 32'h2004_0001;
      6: w = 32'h0800_0000;
      default: w = 32'h0;
    endcase
    if (k == 1 && idx == 3) w = 32'h0022_0020;
    if (idx >= ((k == 1) ? 32'd5 : 32'd64)) w = 32'h0;
    return w;
  endfunction

  task automatic decode(input int k, output logic [31:0] npc, output bit wr,
                        output int dst, output logic [31:0] val);
    logic [31:0] ir, a, b, imm, pc4;
    ir  = rom_word(k, m_pc[k]);
    a   = m_rf[k][ir[25:21]];
    b   = m_rf[k][ir[20:16]];
    imm = {{16{ir[15]}}, ir[15:0]};
    pc4 = m_pc[k] + 32'd4;
    npc = pc4; wr = 0; dst = 0; val = 0;
    case (ir[31:26])
      6'h00: begin
        dst = int'(ir[15:11]);
        wr  = 1;
        case (ir[5:0])
          6'h20: val = a + b;
          6'h22: val = a - b;
          6'h24: val = a & b;
          6'h25: val = a | b;
          6'h2A: val = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
          default: wr = 0;
        endcase
      end
      6'h08: begin dst = int'(ir[20:16]); val = a + imm; wr = 1; end
      6'h04: if (a == b) npc = pc4 + imm * 32'd4;
      6'h02: npc = {pc4[31:28], ir[25:0], 2'b00};
      default: ;
    endcase
  endtask

  task automatic model_step(input int k, input bit rst);
    logic [31:0] npc, val;
    bit wr;
    int dst;
    if (rst) begin
      m_pc[k] = 32'h0;
      for (int i = 0; i < 32; i++) m_rf[k][i] = 32'h0;
    end else begin
      decode(k, npc, wr, dst, val);
      if (wr && dst != 0) m_rf[k][dst] = val;
      m_pc[k] = npc;
    end
  endtask

  // ---------------- checking ----------------
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp)
    else begin
      mismatched++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    logic [31:0] npc, val;
    bit wr;
    int dst;
    decode(0, npc, wr, dst, val);
    chk("pcQ", pcQ, m_pc[0]);
    chk("instruction", instruction, rom_word(0, m_pc[0]));
    chk("pcD", pcD, npc);
    chk("regWriteEnable", 32'(regWriteEnable), 32'(wr));
    chk("yesWrite0", 32'(dut.theRegisters.yesWrite0), 32'(wr && dst == 0));
    for (int i = 0; i < 32; i++)
      chk($sformatf("r%0d", i), dut.theRegisters.regs_q[i], m_rf[0][i]);
    decode(1, npc, wr, dst, val);
    chk("v.pcQ", pcQ2, m_pc[1]);
    chk("v.instruction", instruction2, rom_word(1, m_pc[1]));
    chk("v.pcD", pcD2, npc);
    chk("v.regWriteEnable", 32'(regWriteEnable2), 32'(wr));
    chk("v.yesWrite0", 32'(dut2.theRegisters.yesWrite0), 32'(wr && dst == 0));
    for (int i = 0; i < 32; i++)
      chk($sformatf("v.r%0d", i), dut2.theRegisters.regs_q[i], m_rf[1][i]);
  endtask

  task automatic tick();
    bit rst;
    @(posedge clock);
    rst = !resetN;
    model_step(0, rst);
    model_step(1, rst);
    @(negedge clock);
    if (chk_en) check_all();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int seen;
    resetN = 1'b0;
    tick();
    chk_en = 1;
    tick();
    resetN = 1'b1;

    // Out of reset
    chk("rst.pcQ", pcQ, 32'h0);
    chk("rst.instruction", instruction, 32'h2001_0005);
    chk("rst.pcD", pcD, 32'h4);
    chk("rst.regWriteEnable", 32'(regWriteEnable), 32'd1);
    chk("rst.yesWrite0", 32'(dut.theRegisters.yesWrite0), 32'd0);

    // First three instructions retire
    repeat (3) tick();
    chk("run3.pcQ", pcQ, 32'h0C);
    chk("run3.instruction", instruction, 32'h0);
    chk("run3.regWriteEnable", 32'(regWriteEnable), 32'd0);
    chk("run3.r1", dut.theRegisters.regs_q[1], 32'd5);
    chk("run3.r2", dut.theRegisters.regs_q[2], 32'd10);
    chk("run3.r3", dut.theRegisters.regs_q[3], 32'd15);
    chk("rd0.instruction", instruction2, 32'h0022_0020);
    chk("rd0.regWriteEnable", 32'(regWriteEnable2), 32'd1);
    chk("rd0.yesWrite0", 32'(dut2.theRegisters.yesWrite0), 32'd1);

    tick();
    chk("rd0.r0", dut2.theRegisters.regs_q[0], 32'h0);
    chk("beq.pcQ", pcQ, 32'h10);
    chk("beq.pcD", pcD, 32'h18);
    chk("beq.regWriteEnable", 32'(regWriteEnable), 32'd0);

    tick();
    chk("j.pcQ", pcQ, 32'h18);
    chk("beq.r4", dut.theRegisters.regs_q[4], 32'h0);
    chk("j.pcD", pcD, 32'h0);
    chk("j.regWriteEnable", 32'(regWriteEnable), 32'd0);
    chk("oob.instruction", instruction2, 32'h0);

    tick();
    chk("loop.pcQ", pcQ, 32'h0);
    repeat (3) tick();
    chk("loop.r1", dut.theRegisters.regs_q[1], 32'd5);
    chk("loop.r2", dut.theRegisters.regs_q[2], 32'd10);
    chk("loop.r3", dut.theRegisters.regs_q[3], 32'd15);

    // Reset while the add at 0x08 is pending
    seen = 0;
    for (int i = 0; i < 20 && seen == 0; i++) begin
      if (pcQ == 32'h08) seen = 1;
      else tick();
    end
    chk("midrst.reach08", 32'(seen), 32'd1);
    resetN = 1'b0;
    tick();
    resetN = 1'b1;
    chk("midrst.pcQ", pcQ, 32'h0);
    chk("midrst.r3", dut.theRegisters.regs_q[3], 32'h0);

    // Randomised run lengths and reset pulses, model-checked every cycle
    for (int r = 0; r < 8; r++) begin
      repeat ($urandom_range(1, 15)) tick();
      resetN = 1'b0;
      repeat ($urandom_range(1, 3)) tick();
      resetN = 1'b1;
    end
    repeat (20) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
